// File: rtl/tempsens_pkg.sv
// Shared types and defaults for the temperature-sensor host requester.
// Holds the FSM state encoding, command codes and sample width.
package tempsens_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [7:0] START_CODE_DEF = 8'h00;
    localparam logic [7:0] STOP_CODE_DEF  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SEND_START,
        WAIT_LO,
        WAIT_HI,
        SEND_STOP
    } state_e;

endpackage

// File: rtl/tempsens_byte_timer.sv
// Saturating inter-byte timer with clear/enable.
// tc is high once LIMIT cycles have elapsed since the last clear.
module tempsens_byte_timer #(
    parameter int TMR_W = 20,
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(LIMIT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/tempsens_host_requester.sv
// Host-side requester: sends START/STOP, reassembles low/high byte
// pairs into 16-bit samples and aborts the session on a stalled link.
module tempsens_host_requester
    import tempsens_pkg::*;
#(
    parameter logic [7:0] START_CODE     = START_CODE_DEF,
    parameter logic [7:0] STOP_CODE      = STOP_CODE_DEF,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TMR_W          = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        active,
    output logic        timeout_err
);

    state_e               state_q, state_d;
    logic [7:0]           lo_q, lo_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 rx_take;
    logic                 tmr_clr;
    logic                 tmr_en;
    logic                 tmr_tc;

    assign tmr_en  = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    assign tmr_clr = (state_d != state_q) || rx_take;

    tempsens_byte_timer #(
        .TMR_W (TMR_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // Session FSM: command handshakes, byte pairing, stop and timeout.
    always_comb begin
        state_d        = state_q;
        lo_d           = lo_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        tx_data_d      = tx_data_q;
        tx_send        = 1'b0;
        timeout_err    = 1'b0;
        rx_take        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND_START;
                end
            end
            SEND_START: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!tx_busy) begin
                    tx_send   = 1'b1;
                    tx_data_d = START_CODE;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (stop) begin
                    state_d = SEND_STOP;
                end else if (rx_ready) begin
                    rx_take = 1'b1;
                    lo_d    = rx_data;
                    state_d = WAIT_HI;
                end else if (tmr_tc) begin
                    timeout_err = 1'b1;
                    state_d     = SEND_STOP;
                end
            end
            WAIT_HI: begin
                if (rx_ready) begin
                    rx_take        = 1'b1;
                    sample_d       = {rx_data, lo_q};
                    sample_valid_d = 1'b1;
                    state_d        = stop ? SEND_STOP : WAIT_LO;
                end else if (stop) begin
                    state_d = SEND_STOP;
                end else if (tmr_tc) begin
                    timeout_err = 1'b1;
                    state_d     = SEND_STOP;
                end
            end
            SEND_STOP: begin
                if (!tx_busy) begin
                    tx_send   = 1'b1;
                    tx_data_d = STOP_CODE;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            lo_q           <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            tx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            lo_q           <= lo_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign tx_data      = tx_data_d;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_tempsens_host_requester.sv
// Scoreboard bench for tempsens_host_requester.
// Stimulus pushes expected tx bytes / samples / timeouts; a monitor pops them.
module tb_tempsens_host_requester;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] sample;
    logic        sample_valid;
    logic        active;
    logic        timeout_err;

    tempsens_host_requester #(
        .START_CODE     (8'h00),
        .STOP_CODE      (8'hFF),
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .active       (active),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_s[$];
    int          exp_to = 0;

    int tx_cnt = 0;
    int sv_cnt = 0;
    int to_cnt = 0;
    int last_tx_cyc = -1;
    int last_sv_cyc = -1;
    int last_to_cyc = -1;
    int rx_cyc = 0;

    // reference model of the byte-pairing session
    bit          m_wait = 0;
    bit          m_has_lo = 0;
    logic [7:0]  m_lo = 0;
    logic [15:0] m_last = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", nm, act);
    endtask

    // monitor: pop and compare every DUT output event
    always @(negedge clk) begin
        if (tx_send) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            if (exp_tx.size() == 0) flag("tx_unexpected", tx_data);
            else chk("tx_data", tx_data, exp_tx.pop_front());
        end
        if (sample_valid) begin
            sv_cnt++;
            last_sv_cyc = cyc;
            if (exp_s.size() == 0) flag("sample_unexpected", sample);
            else chk("sample", sample, exp_s.pop_front());
        end
        if (timeout_err) begin
            to_cnt++;
            last_to_cyc = cyc;
            if (exp_to == 0) flag("timeout_unexpected", 32'd1);
            else exp_to--;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input bit lat_chk);
        int s;
        exp_tx.push_back(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        if (lat_chk) begin
            mid();
            chk("start_to_tx", last_tx_cyc, s);
        end
        tick();
        m_wait = 1;
        m_has_lo = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data = b;
        rx_cyc = cyc;
        tick();
        rx_ready = 1'b0;
        rx_data = 8'($urandom);
        if (m_wait) begin
            if (!m_has_lo) begin
                m_lo = b;
                m_has_lo = 1;
            end else begin
                m_last = {b, m_lo};
                exp_s.push_back(m_last);
                m_has_lo = 0;
            end
        end
    endtask

    task automatic do_stop;
        exp_tx.push_back(8'hFF);
        m_wait = 0;
        m_has_lo = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        mid();
        chk("active_in_send_stop", active, 1'b1);
        tick();
        chk("active_after_stop", active, 1'b0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tx_send"}, tx_send, 1'b0);
        chk({nm, "_tx_data"}, tx_data, 8'h00);
        chk({nm, "_sample"}, sample, 16'h0000);
        chk({nm, "_sample_valid"}, sample_valid, 1'b0);
        chk({nm, "_active"}, active, 1'b0);
        chk({nm, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=hang required=finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int s0;
        logic [7:0] b;
        repeat (3) tick();
        reset = 1'b0;
        chk_zero("reset");

        // basic pair
        do_start(1);
        rx_byte(8'h34);
        rx_byte(8'h12);
        mid();
        chk("sv_latency", last_sv_cyc, rx_cyc + 1);
        chk("sample_basic", sample, 16'h1234);

        // stream: fixed then random pairs with random gaps
        tick();
        rx_byte(8'h78); rx_byte(8'h56);
        rx_byte(8'hBC); rx_byte(8'h9A);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 6)) tick();
            rx_byte(8'($urandom));
            repeat ($urandom_range(0, 6)) tick();
            rx_byte(8'($urandom));
        end
        tick();
        chk("sample_stream_last", sample, m_last);
        do_stop();

        // busy backpressure on START
        tx_busy = 1'b1;
        n0 = tx_cnt;
        exp_tx.push_back(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("busy_no_tx", tx_cnt, n0);
        chk("busy_active", active, 1'b1);
        tx_busy = 1'b0;
        tick();
        tick();
        chk("busy_one_tx", tx_cnt, n0 + 1);
        m_wait = 1;
        m_has_lo = 0;
        rx_byte(8'($urandom));
        rx_byte(8'($urandom));
        tick();
        do_stop();

        // stop while START still pending: no tx at all
        n0 = tx_cnt;
        tx_busy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tx_busy = 1'b0;
        tick();
        tick();
        chk("stop_in_send_start_tx", tx_cnt, n0);
        chk("stop_in_send_start_idle", active, 1'b0);

        // timeout after a lone low byte
        do_start(0);
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'hAA);
        s0 = rx_cyc;
        n0 = to_cnt;
        exp_to++;
        exp_tx.push_back(8'hFF);
        m_wait = 0;
        m_has_lo = 0;
        for (int i = 0; i < 80 && to_cnt == n0; i++) mid();
        chk("timeout_seen", to_cnt, n0 + 1);
        chk("timeout_cycle", last_to_cyc, s0 + TO);
        tick();
        tick();
        chk("timeout_idle", active, 1'b0);
        chk("timeout_sample_kept", sample, m_last);

        // byte arriving exactly in the timeout cycle is accepted
        do_start(0);
        rx_byte(8'h01);
        rx_byte(8'h02);
        n0 = to_cnt;
        repeat (TO - 1) tick();
        rx_byte(8'h5A);
        repeat (10) tick();
        rx_byte(8'hA5);
        mid();
        chk("edge_no_timeout", to_cnt, n0);
        chk("edge_sample", sample, 16'hA55A);
        tick();
        do_stop();

        // stop mid-pair discards the low byte; late byte ignored
        do_start(0);
        n0 = sv_cnt;
        rx_byte(8'h11);
        do_stop();
        rx_byte(8'h22);
        repeat (3) tick();
        chk("stop_mid_no_sv", sv_cnt, n0);
        chk("late_rx_idle", active, 1'b0);

        // simultaneous stop and high byte: sample completes, then STOP
        do_start(0);
        rx_byte(8'h21);
        exp_s.push_back(16'h4321);
        exp_tx.push_back(8'hFF);
        m_wait = 0;
        m_has_lo = 0;
        m_last = 16'h4321;
        rx_ready = 1'b1;
        rx_data = 8'h43;
        stop = 1'b1;
        tick();
        rx_ready = 1'b0;
        stop = 1'b0;
        mid();
        chk("simul_sample", sample, 16'h4321);
        tick();
        chk("simul_idle", active, 1'b0);

        // reset in WAIT_HI, then a clean new session
        do_start(0);
        rx_byte(8'h77);
        reset = 1'b1;
        tick();
        mid();
        chk_zero("midreset");
        reset = 1'b0;
        m_wait = 0;
        m_has_lo = 0;
        m_last = 16'h0000;
        tick();
        do_start(1);
        b = 8'($urandom);
        rx_byte(8'hCD);
        rx_byte(8'hAB);
        mid();
        chk("after_reset_sample", sample, 16'hABCD);
        tick();
        rx_byte(b);
        tick();
        do_stop();

        repeat (3) tick();
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("sample_queue_drained", exp_s.size(), 0);
        chk("timeout_queue_drained", exp_to, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
